serial_rx_port: RTL

Serial receiver for the far end of the SAP-II output-port-4 serial link. It takes the 1-bit line, deserialises 8N1 frames (LSB first), and holds the received byte for an 8-bit consumer with a ready/acknowledge handshake, the same one input port 1 uses. It also flags overrun and framing errors. It sits outside the CPU as the peripheral that talks to port 4, or feeds input port 2 in loopback.

---
 rtl/serial_rx_port.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/serial_rx_port.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx_port
// Purpose  : 8N1 serial receiver (LSB first) for the SAP-II port-4 link.
//            Holds the received byte for an 8-bit consumer using a
//            ready/acknowledge handshake, and flags overrun and framing
//            errors.
// Ports    : CLK           - system clock, rising edge
//            CLR           - asynchronous active-high reset
//            serial_in     - serial line (idle high, async to CLK)
//            acknowledge   - consumer accepts the held byte
//            rx_data[7:0]  - last good received byte
//            ready         - rx_data holds an unacknowledged byte
//            overrun       - a frame completed while ready was high
//            framing_error - stop bit sampled low
//            busy          - receiver state is not IDLE
//            parity_error  - (SERIAL_RX_PARITY_EN only) even-parity failure
// Options  : define SERIAL_RX_PARITY_EN for 8E1 frames with a parity check
// Revision : 1.0 - initial release
// ============================================================================
module serial_rx_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       serial_in,
  input  logic       acknowledge,
  output logic [7:0] rx_data,
  output logic       ready,
  output logic       overrun,
  output logic       framing_error,
`ifdef SERIAL_RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       busy
);

  localparam logic [CNT_W-1:0] c_HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] c_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             ready_q, ready_d;
  logic             overrun_q, overrun_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;
  logic             sync1_q, sin_q, prev_q;
`ifdef SERIAL_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             perr_q, perr_d;
`endif

  // Two-flop synchroniser; prev_q holds the previous synchronised value so
  // a start is only recognised on a genuine 1 -> 0 transition.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sync1_q <= 1'b1;
      sin_q   <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sin_q   <= sync1_q;
      prev_q  <= sin_q;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    ferr_d    = ferr_q;
`ifdef SERIAL_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = perr_q;
`endif

    // Acknowledge clears status first; a frame completing on the same edge
    // overrides below, so the new byte wins.
    if (acknowledge) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
      ferr_d    = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_d    = 1'b0;
`endif
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sin_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == c_HALF_M1) begin
          cnt_d = '0;
          idx_d = 3'd0;
          // A line back high at mid-start was a glitch.
          state_d = sin_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == c_FULL_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = sin_q;
          if (idx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == c_FULL_M1) begin
          cnt_d     = '0;
          par_bad_d = ^{shift_q, sin_q};
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == c_FULL_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!sin_q) begin
            ferr_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
          end else if (par_bad_q) begin
            perr_d = 1'b1;
`endif
          end else if (!ready_q || acknowledge) begin
            rx_data_d = shift_q;
            ready_d   = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign rx_data       = rx_data_q;
  assign ready         = ready_q;
  assign overrun       = overrun_q;
  assign framing_error = ferr_q;
  assign busy          = busy_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_error  = perr_q;
`endif

endmodule
`default_nettype wire
